// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the word-line data memory port. Takes one load/store
//   request at a time from the core and drives a memory built from four byte
//   banks (async read, write on the rising clock edge). An access that crosses
//   a line boundary is split into two line accesses, first the lower line and
//   then the next line (the line address wraps at the top of memory). Load
//   results are sign- or zero-extended to 32 bits.
//
//   Build option: define MISALIGN_TRAP_EN to trap non-naturally-aligned
//   halfword/word accesses. A trapped request returns resp_error with no memory
//   cycle. Without the macro, misaligned accesses are serviced and split when
//   they cross a line boundary, and resp_error is tied low.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 1x word
//   req_unsigned          load extension: 1 zero, 0 sign
//   req_addr, req_wdata   byte address, LSB-justified store data
//   resp_valid            one-cycle completion pulse per accepted request
//   resp_rdata            extended load data (0 for stores)
//   resp_error            misalignment trap flag
//   mem_addr/mem_wdata    line address and lane-aligned write data
//   mem_be/mem_we         byte-lane enables and write strobe
//   mem_rdata             combinational read data for mem_addr
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACC0 = 3'd1;
  localparam logic [2:0] ST_ACC1 = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              accept;
  logic              trap;
  logic              split;

  logic [ADDR_W-3:0] line0_p0;
  logic [ADDR_W-3:0] line1_p0;
  logic [1:0]        off_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic              we_p0;
  logic [7:0]        mask_p0;
  logic [63:0]       wd_p0;
  logic [63:0]       ldbuf_p1;

  // Lane mask spanning two lines: nb ones shifted up by the byte offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Align the two captured lines down by the offset, then extend.
  function automatic logic [31:0] extend_load(input logic [63:0] buf64, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] raw;
    logic [31:0] res;
    raw = buf64 >> {off, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
      2'b01:   res = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw[31:0];
    endcase
    return res;
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign trap       = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
  assign resp_error = (state == ST_ERR);
`else
  assign trap       = 1'b0;
  assign resp_error = 1'b0;
`endif

  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign split      = |mask_p0[7:4];
  assign line1_p0   = line0_p0 + {{(ADDR_W-3){1'b0}}, 1'b1};
  assign resp_valid = (state == ST_RESP) || (state == ST_ERR);
  assign resp_rdata = (state == ST_RESP && !we_p0) ? extend_load(ldbuf_p1, off_p0, size_p0, uns_p0) : 32'd0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = trap ? ST_ERR : ST_ACC0;
      ST_ACC0: state_nxt = split ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // p0: request captured at accept
  always_ff @(posedge clock) begin
    if (accept) begin
      line0_p0 <= req_addr[ADDR_W-1:2];
      off_p0   <= req_addr[1:0];
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      we_p0    <= req_we;
      mask_p0  <= lane_mask(req_size, req_addr[1:0]);
      wd_p0    <= {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
    end
  end

  // p1: load data captured per line access
  always_ff @(posedge clock) begin
    if (state == ST_ACC0 && !we_p0) ldbuf_p1[31:0]  <= mem_rdata;
    if (state == ST_ACC1 && !we_p0) ldbuf_p1[63:32] <= mem_rdata;
  end

  // Memory port is decoded from state so an asynchronous reset drops mem_we at once.
  always_comb begin
    mem_addr  = '0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    mem_we    = 1'b0;
    case (state)
      ST_ACC0: begin
        mem_addr  = line0_p0;
        mem_be    = mask_p0[3:0];
        mem_wdata = wd_p0[31:0];
        mem_we    = we_p0;
      end
      ST_ACC1: begin
        mem_addr  = line1_p0;
        mem_be    = mask_p0[7:4];
        mem_wdata = wd_p0[63:32];
        mem_we    = we_p0;
      end
      default: ;
    endcase
  end

endmodule
